vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y counters with zero-latency strobes,
// plus hsync/vsync/de delayed by 1+PIPE_DELAY clocks to match a pixel pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_VISIBLE  = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int PIPE_DELAY = 2,
  parameter int H_CNT_W    = 12,
  parameter int V_CNT_W    = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               pix_req,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_SYNC < 1) begin : g_bad_hsync
    $error("vga_timing_gen: H_SYNC must be >= 1");
  end
  if (V_SYNC < 1) begin : g_bad_vsync
    $error("vga_timing_gen: V_SYNC must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << H_CNT_W)) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL-1 does not fit in H_CNT_W");
  end
  if (longint'(V_TOTAL) > (longint'(1) << V_CNT_W)) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL-1 does not fit in V_CNT_W");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  // Decode thresholds kept 32 bits wide so an end bound equal to 2**W cannot wrap.
  localparam logic [31:0] H_VIS  = 32'(H_VISIBLE);
  localparam logic [31:0] H_SS   = 32'(H_VISIBLE + H_FP);
  localparam logic [31:0] H_SE   = 32'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [31:0] H_LAST = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_VIS  = 32'(V_VISIBLE);
  localparam logic [31:0] V_SS   = 32'(V_VISIBLE + V_FP);
  localparam logic [31:0] V_SE   = 32'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [31:0] V_LAST = 32'(V_TOTAL - 1);
  localparam logic        HP     = (H_POL != 0);
  localparam logic        VP     = (V_POL != 0);
  localparam logic [2:0]  IDLE   = {HP, VP, 1'b0};

  logic [31:0] xi, yi;
  logic        h_act, v_act, de_raw;
  logic [2:0]  stage_in;
  logic [2:0]  pipe [PIPE_DELAY+1];

  assign xi = 32'(x);
  assign yi = 32'(y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (!en) begin
      x <= '0;
      y <= '0;
    end else if (xi == H_LAST) begin
      x <= '0;
      y <= (yi == V_LAST) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  assign h_act       = (xi >= H_SS) && (xi < H_SE);
  assign v_act       = (yi >= V_SS) && (yi < V_SE);
  assign de_raw      = (xi < H_VIS) && (yi < V_VIS) && en;
  assign pix_req     = de_raw;
  assign line_start  = (x == '0) && en;
  assign frame_start = line_start && (y == '0);
  assign vblank      = (yi >= V_VIS);

  // Polarity is folded in ahead of the registers so the outputs come straight off flops.
  assign stage_in = en ? {h_act ^ HP, v_act ^ VP, de_raw} : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= IDLE;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {hsync, vsync, de} = pipe[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800x600 timing, a tiny 8x6 raster,
// and the tiny raster with inverted sync polarity and a 2-stage delay.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n = 1'b0;
  logic en_def = 1'b0, en_tiny = 1'b0, en_inv = 1'b0;

  logic [11:0] d_x;  logic [10:0] d_y;
  logic d_pix, d_ls, d_fs, d_vb, d_hs, d_vs, d_de;
  logic [3:0] t_x;   logic [2:0] t_y;
  logic t_pix, t_ls, t_fs, t_vb, t_hs, t_vs, t_de;
  logic [3:0] i_x;   logic [2:0] i_y;
  logic i_pix, i_ls, i_fs, i_vb, i_hs, i_vs, i_de;

  int total = 0;
  int bad = 0;

  always #5 clk = clk_run ? ~clk : clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en_def), .x(d_x), .y(d_y), .pix_req(d_pix),
    .line_start(d_ls), .frame_start(d_fs), .vblank(d_vb),
    .hsync(d_hs), .vsync(d_vs), .de(d_de));

  vga_timing_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .PIPE_DELAY(0), .H_CNT_W(4), .V_CNT_W(3)) u_tiny (
    .clk(clk), .rst_n(rst_n), .en(en_tiny), .x(t_x), .y(t_y), .pix_req(t_pix),
    .line_start(t_ls), .frame_start(t_fs), .vblank(t_vb),
    .hsync(t_hs), .vsync(t_vs), .de(t_de));

  vga_timing_gen #(.H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1), .V_POL(1), .PIPE_DELAY(2),
                   .H_CNT_W(4), .V_CNT_W(3)) u_inv (
    .clk(clk), .rst_n(rst_n), .en(en_inv), .x(i_x), .y(i_y), .pix_req(i_pix),
    .line_start(i_ls), .frame_start(i_fs), .vblank(i_vb),
    .hsync(i_hs), .vsync(i_vs), .de(i_de));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d_hs_cnt, d_hs_first, d_de_cnt, d_de_first, d_pix_cnt, d_vs_cnt, d_vb_cnt;
  int t_hs_cnt, t_hs_first, t_vs_cnt, t_vs_first, t_de_cnt, t_fs_cnt, t_fs_first, t_vb_cnt;
  int i_hs_cnt, i_hs_first, i_vs_cnt, i_vs_first;
  logic [7:0] t_de_pat;
  logic found;

  initial begin
    d_hs_cnt = 0; d_hs_first = -1; d_de_cnt = 0; d_de_first = -1;
    d_pix_cnt = 0; d_vs_cnt = 0; d_vb_cnt = 0;
    t_hs_cnt = 0; t_hs_first = -1; t_vs_cnt = 0; t_vs_first = -1;
    t_de_cnt = 0; t_fs_cnt = 0; t_fs_first = -1; t_vb_cnt = 0;
    i_hs_cnt = 0; i_hs_first = -1; i_vs_cnt = 0; i_vs_first = -1;
    t_de_pat = '0;

    // reset state
    #12;
    check("rst_x", 32'(d_x), 0);
    check("rst_y", 32'(d_y), 0);
    check("rst_de", 32'(d_de), 0);
    check("rst_hs", 32'(d_hs), 0);
    check("rst_vs", 32'(d_vs), 0);
    check("rst_inv_hs", 32'(i_hs), 1);
    check("rst_inv_vs", 32'(i_vs), 1);

    // idle with en low
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_x", 32'(d_x), 0);
    check("idle_fs", 32'(d_fs), 0);
    check("idle_pix", 32'(d_pix), 0);
    check("idle_inv_hs", 32'(i_hs), 1);
    check("idle_inv_vs", 32'(i_vs), 1);

    // enable; state k=0 is visible before the first edge
    @(negedge clk);
    en_def = 1'b1; en_tiny = 1'b1; en_inv = 1'b1;
    #1;
    check("start_fs", 32'(d_fs), 1);
    check("start_ls", 32'(d_ls), 1);
    check("tiny_start_fs", 32'(t_fs), 1);
    d_pix_cnt = int'(d_pix);

    for (int k = 1; k <= 1200; k++) begin
      tick();
      if (d_hs) begin d_hs_cnt++; if (d_hs_first < 0) d_hs_first = k; end
      if (d_de && k <= 1058) begin d_de_cnt++; if (d_de_first < 0) d_de_first = k; end
      if (d_pix && k <= 1055) d_pix_cnt++;
      if (d_vs) d_vs_cnt++;
      if (d_vb) d_vb_cnt++;
      if (k == 1055) begin
        check("x_last", 32'(d_x), 1055);
        check("y_line0", 32'(d_y), 0);
      end
      if (k == 1056) begin
        check("x_wrap", 32'(d_x), 0);
        check("y_wrap", 32'(d_y), 1);
        check("ls_line1", 32'(d_ls), 1);
        check("fs_line1", 32'(d_fs), 0);
      end
      if (k <= 48) begin
        if (t_hs) begin t_hs_cnt++; if (t_hs_first < 0) t_hs_first = k; end
        if (t_vs) begin t_vs_cnt++; if (t_vs_first < 0) t_vs_first = k; end
        if (t_de) t_de_cnt++;
        if (t_vb) t_vb_cnt++;
      end
      if (k <= 8) t_de_pat[k-1] = t_de;
      if (t_fs) begin t_fs_cnt++; if (t_fs_first < 0) t_fs_first = k; end
      if (k >= 3 && k <= 50) begin
        if (!i_hs) begin i_hs_cnt++; if (i_hs_first < 0) i_hs_first = k; end
        if (!i_vs) begin i_vs_cnt++; if (i_vs_first < 0) i_vs_first = k; end
      end
    end

    check("def_hs_first", 32'(d_hs_first), 843);
    check("def_hs_width", 32'(d_hs_cnt), 128);
    check("def_de_first", 32'(d_de_first), 3);
    check("def_de_width", 32'(d_de_cnt), 800);
    check("def_pix_cnt", 32'(d_pix_cnt), 800);
    check("def_vs_none", 32'(d_vs_cnt), 0);
    check("def_vb_none", 32'(d_vb_cnt), 0);

    check("tiny_hs_first", 32'(t_hs_first), 6);
    check("tiny_hs_cnt", 32'(t_hs_cnt), 12);
    check("tiny_vs_first", 32'(t_vs_first), 33);
    check("tiny_vs_cnt", 32'(t_vs_cnt), 8);
    check("tiny_de_cnt", 32'(t_de_cnt), 12);
    check("tiny_de_pat", 32'(t_de_pat), 32'h0F);
    check("tiny_vb_cnt", 32'(t_vb_cnt), 24);
    check("tiny_fs_first", 32'(t_fs_first), 48);
    check("tiny_fs_cnt", 32'(t_fs_cnt), 25);

    check("inv_hs_first", 32'(i_hs_first), 8);
    check("inv_hs_low", 32'(i_hs_cnt), 12);
    check("inv_vs_first", 32'(i_vs_first), 35);
    check("inv_vs_low", 32'(i_vs_cnt), 8);

    // drop en mid-hsync on line 1
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      if (d_x == 12'd900 && d_y == 11'd1) found = 1'b1;
      else tick();
    end
    check("wait_x900", 32'(found), 1);
    check("pre_drop_hs", 32'(d_hs), 1);
    en_def = 1'b0;
    #1;
    check("drop_pix", 32'(d_pix), 0);
    check("drop_ls", 32'(d_ls), 0);
    tick();
    check("drop_x", 32'(d_x), 0);
    check("drop_y", 32'(d_y), 0);
    tick();
    tick();
    check("drop_hs", 32'(d_hs), 0);
    check("drop_de", 32'(d_de), 0);
    check("drop_vs", 32'(d_vs), 0);
    repeat (4) tick();
    check("hold_x", 32'(d_x), 0);
    check("hold_hs", 32'(d_hs), 0);

    // re-enable gives frame_start on the first cycle
    en_def = 1'b1;
    #1;
    check("reen_fs", 32'(d_fs), 1);
    check("reen_ls", 32'(d_ls), 1);

    // async reset mid-hsync with the clock stopped
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      if (d_hs) found = 1'b1;
    end
    check("wait_hs", 32'(found), 1);
    check("reen_hs_x", 32'(d_x), 843);
    @(negedge clk);
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    check("arst_hs", 32'(d_hs), 0);
    check("arst_vs", 32'(d_vs), 0);
    check("arst_de", 32'(d_de), 0);
    check("arst_x", 32'(d_x), 0);
    check("arst_y", 32'(d_y), 0);
    check("arst_inv_hs", 32'(i_hs), 1);
    check("arst_inv_vs", 32'(i_vs), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
